// File: rtl/io_bus_controller_pkg.sv
// Shared constants for the memory-mapped IO block.
// Holds the register address map, the KEY status field offsets and the
// register-select enum that the top-level decoder produces.
package io_bus_controller_pkg;

  localparam logic [31:0] IO_ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] IO_ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] IO_ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] IO_ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] IO_ADDR_SW   = 32'hF000_0014;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW   = 10;

  // Layout of the KEY status word returned on a load.
  localparam int KEY_LEVEL_LSB  = 0;
  localparam int KEY_STICKY_LSB = 4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_HEX,
    SEL_LEDR,
    SEL_LEDG,
    SEL_KEY,
    SEL_SW
  } io_sel_e;

endpackage

// File: rtl/io_bus_controller_seven_seg_decoder.sv
// seven_seg_decoder: hex nibble to seven-segment pattern.
// Ports:
//   digit - 4-bit value 0..F
//   seg   - segments {g,f,e,d,c,b,a}, active-low (0 = lit)
module seven_seg_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b111_1111;
    case (digit)
      4'h0: seg = 7'b100_0000;
      4'h1: seg = 7'b111_1001;
      4'h2: seg = 7'b010_0100;
      4'h3: seg = 7'b011_0000;
      4'h4: seg = 7'b001_1001;
      4'h5: seg = 7'b001_0010;
      4'h6: seg = 7'b000_0010;
      4'h7: seg = 7'b111_1000;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b001_0000;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b000_0011;
      4'hC: seg = 7'b100_0110;
      4'hD: seg = 7'b010_0001;
      4'hE: seg = 7'b000_0110;
      4'hF: seg = 7'b000_1110;
      default: seg = 7'b111_1111;
    endcase
  end

endmodule

// File: rtl/io_bus_controller.sv
// io_bus_controller: memory-mapped IO registers for the board peripherals.
// Ports:
//   clk, reset_n      - clock (rising edge), async active-low reset
//   addr, wdata       - byte address and store data from the datapath
//   we, re            - store / load strobes
//   rdata, rd_valid   - registered load data and its one-cycle qualifier
//   io_hit            - combinational: addr is one of the five IO registers
//   KEY, SW           - raw buttons (0 = pressed) and slide switches
//   LEDR, LEDG        - red / green LED registers
//   HEX0..HEX3        - seven-segment digits of the 16-bit HEX register
//
// Load handshake: a load is accepted in any cycle where re=1, we=0 and
// io_hit=1; there is no back-pressure. Exactly one cycle later rd_valid
// pulses for one cycle with rdata valid. rdata holds its value otherwise.
// A simultaneous store wins and the load is dropped.
module io_bus_controller
  import io_bus_controller_pkg::*;
#(
  parameter int                DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDR_HEX        = IO_ADDR_HEX,
  parameter logic [DBITS-1:0]  ADDR_LEDR       = IO_ADDR_LEDR,
  parameter logic [DBITS-1:0]  ADDR_LEDG       = IO_ADDR_LEDG,
  parameter logic [DBITS-1:0]  ADDR_KEY        = IO_ADDR_KEY,
  parameter logic [DBITS-1:0]  ADDR_SW         = IO_ADDR_SW,
  parameter int                DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [DBITS-1:0] rdata,
  output logic             rd_valid,
  output logic             io_hit,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  io_sel_e             sel;
  logic                store_fire;
  logic                load_fire;
  logic [15:0]         hex;
  logic [NUM_KEYS-1:0] key_s1, key_s2;
  logic [NUM_SW-1:0]   sw_s1, sw_s2;
  logic [NUM_KEYS-1:0] key_pressed;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] sticky;
  logic [NUM_KEYS-1:0] accept_rise;
  logic [NUM_KEYS-1:0] sticky_next;
  logic [CNT_W-1:0]    db_cnt [NUM_KEYS];
  logic [DBITS-1:0]    load_data;
  logic                unused_wdata;

  // Only the low 16 store bits reach any register.
  assign unused_wdata = ^wdata[DBITS-1:16];

  always_comb begin
    sel = SEL_NONE;
    if      (addr == ADDR_HEX)  sel = SEL_HEX;
    else if (addr == ADDR_LEDR) sel = SEL_LEDR;
    else if (addr == ADDR_LEDG) sel = SEL_LEDG;
    else if (addr == ADDR_KEY)  sel = SEL_KEY;
    else if (addr == ADDR_SW)   sel = SEL_SW;
  end

  assign io_hit     = (sel != SEL_NONE);
  assign store_fire = we & io_hit;
  assign load_fire  = re & ~we & io_hit;

  // Buttons are active-low on the board; internally 1 = pressed.
  assign key_pressed = ~key_s2;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      accept_rise[i] = key_pressed[i] & ~level[i] & (db_cnt[i] == CNT_MAX);
    end
    // Clear-on-read first, then set: a press accepted in the same cycle as
    // a KEY load survives the clear, while the load still sees the old bit.
    sticky_next = sticky;
    if (load_fire && sel == SEL_KEY) sticky_next = '0;
    sticky_next = sticky_next | accept_rise;
  end

  always_comb begin
    load_data = '0;
    case (sel)
      SEL_HEX:  load_data[15:0] = hex;
      SEL_LEDR: load_data[9:0]  = LEDR;
      SEL_LEDG: load_data[7:0]  = LEDG;
      SEL_KEY: begin
        load_data[KEY_LEVEL_LSB  +: NUM_KEYS] = level;
        load_data[KEY_STICKY_LSB +: NUM_KEYS] = sticky;
      end
      SEL_SW:   load_data[NUM_SW-1:0] = sw_s2;
      default:  load_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= '0;
      key_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: count cycles the synchronized level differs from the accepted
  // one; any return to the accepted level restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level  <= '0;
      sticky <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      sticky <= sticky_next;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_pressed[i] != level[i]) begin
          if (db_cnt[i] == CNT_MAX) begin
            level[i]  <= key_pressed[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex  <= '0;
      LEDR <= '0;
      LEDG <= '0;
    end else if (store_fire) begin
      case (sel)
        SEL_HEX:  hex  <= wdata[15:0];
        SEL_LEDR: LEDR <= wdata[9:0];
        SEL_LEDG: LEDG <= wdata[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= load_fire;
      if (load_fire) rdata <= load_data;
    end
  end

  seven_seg_decoder u_hex0 (.digit(hex[3:0]),   .seg(HEX0));
  seven_seg_decoder u_hex1 (.digit(hex[7:4]),   .seg(HEX1));
  seven_seg_decoder u_hex2 (.digit(hex[11:8]),  .seg(HEX2));
  seven_seg_decoder u_hex3 (.digit(hex[15:12]), .seg(HEX3));

endmodule

// File: tb/tb_io_bus_controller.sv
module tb_io_bus_controller;

  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;

  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_B = 7'b000_0011;
  localparam logic [6:0] SEG_E = 7'b000_0110;
  localparam logic [6:0] SEG_F = 7'b000_1110;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        io_hit;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int total = 0;
  int bad   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  io_bus_controller dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rd_valid(rd_valid), .io_hit(io_hit), .KEY(KEY), .SW(SW),
    .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle 1 time unit past it
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    tick(1);
    we = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; re = 1'b1; we = 1'b0;
    tick(1);
    re = 1'b0;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"}, rdata, exp);
    tick(1);
    check({tag, "_pulse_end"}, {31'd0, rd_valid}, 32'd0);
    check({tag, "_hold"}, rdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    KEY = 4'hF; SW = '0;
    #12;
    check("rst_rdata", rdata, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_ledr", {22'd0, LEDR}, 32'd0);
    check("rst_ledg", {24'd0, LEDG}, 32'd0);
    check("rst_hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, SEG_0, SEG_0, SEG_0, SEG_0});
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);

    // address decode
    addr = A_SW; #1;
    check("io_hit_sw", {31'd0, io_hit}, 32'd1);
    addr = 32'hF000_000C; #1;
    check("io_hit_gap", {31'd0, io_hit}, 32'd0);

    // HEX store/load
    do_store(A_HEX, 32'h0000_BEEF);
    check("hex_digits", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, SEG_B, SEG_E, SEG_E, SEG_F});
    do_store(A_KEY, 32'h0000_1234);
    do_store(32'hF000_000C, 32'h0000_5678);
    check("hex_untouched", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, SEG_B, SEG_E, SEG_E, SEG_F});
    do_load("load_hex", A_HEX, 32'h0000_BEEF);

    // LEDR/LEDG zero-extended, upper store bits dropped
    do_store(A_LEDR, 32'hFFFF_F955);
    check("ledr_store", {22'd0, LEDR}, 32'h155);
    do_load("load_ledr", A_LEDR, 32'h0000_0155);
    do_store(A_LEDG, 32'h1234_56A5);
    do_load("load_ledg", A_LEDG, 32'h0000_00A5);

    // switches through synchronizer
    SW = 10'h2A5;
    tick(3);
    do_load("load_sw", A_SW, 32'h0000_02A5);

    // held key accepted, sticky clears on read
    KEY = 4'b1011;
    tick(20);
    do_load("load_key1", A_KEY, 32'h0000_0044);
    do_load("load_key2", A_KEY, 32'h0000_0004);
    KEY = 4'hF;
    tick(20);
    do_load("load_key_rel", A_KEY, 32'h0000_0000);

    // bouncing key never accepted
    for (int t = 0; t < 8; t++) begin
      KEY[0] = t[0];
      tick(5);
    end
    KEY = 4'hF;
    tick(20);
    do_load("load_key_bounce", A_KEY, 32'h0000_0000);

    // press accepted on the same edge as a KEY load: old value returned,
    // flag kept. Press lands 18 edges after KEY changes (2 sync + 16 stable).
    KEY = 4'b1110;
    tick(17);
    addr = A_KEY; re = 1'b1;
    tick(1);
    re = 1'b0;
    check("coinc_valid", {31'd0, rd_valid}, 32'd1);
    check("coinc_data", rdata, 32'h0000_0000);
    tick(1);
    do_load("load_key_after", A_KEY, 32'h0000_0011);
    KEY = 4'hF;
    tick(20);

    // store and load together: store wins
    addr = A_LEDR; wdata = 32'h0000_03FF; we = 1'b1; re = 1'b1;
    tick(1);
    we = 1'b0; re = 1'b0;
    check("we_re_ledr", {22'd0, LEDR}, 32'h3FF);
    check("we_re_no_valid", {31'd0, rd_valid}, 32'd0);
    tick(1);
    check("we_re_no_valid2", {31'd0, rd_valid}, 32'd0);

    // async reset during a pending load
    do_store(A_LEDG, 32'h0000_00FF);
    check("ledg_ff", {24'd0, LEDG}, 32'h0000_00FF);
    addr = A_LEDG; re = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check("async_ledg", {24'd0, LEDG}, 32'd0);
    check("async_hex", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, SEG_0, SEG_0, SEG_0, SEG_0});
    check("async_ledr", {22'd0, LEDR}, 32'd0);
    tick(1);
    check("rst_no_valid", {31'd0, rd_valid}, 32'd0);
    re = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_no_valid", {31'd0, rd_valid}, 32'd0);
    check("post_rst_rdata", rdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_bus_controller.md
IO_BUS_CONTROLLER -- requirements
Module: io_bus_controller

Interface
REQ-001 Parameter DBITS, 32, data and address bus width.
REQ-002 Parameter ADDR_HEX, 32'hF0000000, HEX display register address.
REQ-003 Parameter ADDR_LEDR, 32'hF0000004, red LED register address.
REQ-004 Parameter ADDR_LEDG, 32'hF0000008, green LED register address.
REQ-005 Parameter ADDR_KEY, 32'hF0000010, key status register address.
REQ-006 Parameter ADDR_SW, 32'hF0000014, switch register address.
REQ-007 Parameter DEBOUNCE_CYCLES, 16, number of stable cycles before a key level is accepted.
REQ-008 Port clk, input, 1: the single clock, rising edge.
REQ-009 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-010 Port addr, input, DBITS: byte address from the datapath.
REQ-011 Port wdata, input, DBITS: store data.
REQ-012 Port we, input, 1: store strobe.
REQ-013 Port re, input, 1: load strobe.
REQ-014 Port rdata, output, DBITS: load data, registered.
REQ-015 Port rd_valid, output, 1: one-cycle pulse qualifying rdata.
REQ-016 Port io_hit, output, 1: combinational, high when addr equals any of the five register addresses.
REQ-017 Port KEY, input, 4: raw push buttons, 0 = pressed.
REQ-018 Port SW, input, 10: raw slide switches.
REQ-019 Port LEDR, output, 10: red LEDs.
REQ-020 Port LEDG, output, 8: green LEDs.
REQ-021 Ports HEX0..HEX3, output, 7 each: seven-segment digits, active-low segments.

Function
REQ-022 Store: when we=1 and addr matches at a rising edge, the target register is updated at that edge.
- HEX takes wdata[15:0].
- LEDR takes wdata[9:0].
- LEDG takes wdata[7:0].
- KEY, SW and non-matching addresses are ignored.
REQ-023 Load: when re=1, we=0 and io_hit=1, rdata is loaded and rd_valid=1 on the next cycle; latency is exactly 1 cycle.
REQ-024 Load data per register:
- HEX returns {16'b0, hex}.
- LEDR and LEDG return zero-extended values.
- SW returns the synchronized switches, zero-extended.
- KEY returns {24'b0, sticky[3:0], level[3:0]}.
REQ-025 When we=1 and re=1 in the same cycle, the store executes, the load is ignored and rd_valid stays 0.
REQ-026 rdata holds its last value while rd_valid=0.
REQ-027 Each KEY and SW bit is passed through a 2-flop synchronizer before use.
REQ-028 Per-key debounce: a synchronized level differing from the accepted level starts a counter.
- The counter restarts on any bounce.
- The new level is accepted when it has been stable DEBOUNCE_CYCLES consecutive cycles.
- level bit is 1 = pressed.
REQ-029 sticky[i] sets on an accepted 0-to-1 transition of level[i] and clears on a KEY load.
REQ-030 If a press is accepted in the same cycle as a KEY load, the returned sticky bit reflects the old value and the flag remains set afterwards.
REQ-031 HEXn displays hex nibble hex[4n+3:4n], digits 0-F.

Reset
REQ-032 Assertion of reset_n=0 clears immediately: hex, LEDR, LEDG, rdata, rd_valid, sticky, level, debounce counters and synchronizers.
REQ-033 During reset, HEX0..HEX3 show digit 0 (7'b1000000).
REQ-034 A reset during a pending load suppresses that rd_valid pulse.

Structure
REQ-035 The address constants and the KEY field offsets (level bits 3:0, sticky bits 7:4) live in the shared project package.
REQ-036 One sub-module, seven_seg_decoder (4-bit in, 7-bit active-low out), is instantiated four times.

Verification
REQ-037 Store HEX 32'h0000BEEF, then load HEX: HEX3..HEX0 show B,E,E,F, and rdata=32'h0000BEEF with rd_valid one cycle after re.
REQ-038 SW=10'h2A5, wait 3 cycles, load SW: rdata=32'h000002A5.
REQ-039 Hold KEY[2]=0 for 20 cycles, then load KEY: rdata=32'h00000044. A second load returns 32'h00000004.
REQ-040 Toggle KEY[0] every 5 cycles for 40 cycles, then release: sticky[0] and level[0] never set.
REQ-041 Assert we and re together at ADDR_LEDR with wdata=10'h3FF: LEDR=10'h3FF, rd_valid=0.
REQ-042 Assert reset_n low mid-operation after a store of LEDG=8'hFF: LEDG=0 asynchronously, HEX shows 0000, and no rd_valid pulse.
